dma_wr_burst_ctrl: RTL and testbench



---
 rtl/dma_wr_burst_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_dma_wr_burst_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dma_wr_burst_ctrl
// Brief  : Buffers 512-bit stream beats and writes them to host memory as
//          4KB-page-safe AXI4 write bursts. Optional macro: LAST_CHECK_EN.
// Rev    : 1.0
// ============================================================================
module dma_wr_burst_ctrl #(
    parameter int ADDR_W     = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int MAX_BURST  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [31:0]       total_length,
    input  logic [511:0]      data_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [511:0]      m_wdata,
    output logic [63:0]       m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              done,
    output logic              error
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_fcnt_w = c_ptr_w + 1;
    localparam int c_cnt_w  = 27;
    localparam logic [6:0] c_max_burst = 7'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [c_cnt_w-1:0]  r_total_beats, r_accepted, r_issued, r_sent, r_outstanding_b;
    logic [5:0]          r_tail_bytes;
    logic [ADDR_W-1:0]   r_cur_addr, r_awaddr;
    logic [7:0]          r_awlen;
    logic                r_awvalid, r_bready, r_error;
    logic [511:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_fcnt_w-1:0] r_fifo_cnt;
    logic [6:0]          r_q_len [2];
    logic                r_q_wr, r_q_rd;
    logic [1:0]          r_q_cnt;
    logic [6:0]          r_beat_idx;

    logic               w_start_ok, w_fifo_full, w_fifo_empty, w_push, w_pop;
    logic               w_q_empty, w_q_full, w_aw_fire, w_aw_hs, w_b_hs;
    logic               w_wlast, w_final_beat, w_last_err, w_err_set;
    logic [c_cnt_w-1:0] w_start_beats, w_remaining, w_avail;
    logic [6:0]         w_page_room, w_len;

    assign w_start_ok    = start && (r_state == S_IDLE);
    assign w_start_beats = {1'b0, total_length[31:6]} + c_cnt_w'(|total_length[5:0]);
    assign w_fifo_full   = (r_fifo_cnt == c_fcnt_w'(FIFO_DEPTH));
    assign w_fifo_empty  = (r_fifo_cnt == '0);
    assign w_q_empty     = (r_q_cnt == 2'd0);
    assign w_q_full      = (r_q_cnt == 2'd2);
    assign w_push        = valid_i && ready_o;
    assign w_pop         = m_wvalid && m_wready;
    assign w_aw_hs       = r_awvalid && m_awready;
    assign w_b_hs        = m_bvalid && r_bready;
    assign w_remaining   = r_total_beats - r_issued;
    assign w_avail       = r_accepted - r_issued;
    assign w_page_room   = 7'd64 - {1'b0, r_cur_addr[11:6]};
    assign w_wlast       = (r_beat_idx == r_q_len[r_q_rd] - 7'd1);
    assign w_final_beat  = (r_sent == r_total_beats - c_cnt_w'(1));

    always_comb begin
        w_len = c_max_burst;
        if (w_remaining < c_cnt_w'(w_len)) w_len = w_remaining[6:0];
        if (w_page_room < w_len) w_len = w_page_room;
    end

    // Only beats already buffered and not yet claimed by an earlier burst
    // may back a new address, so W never stalls mid-burst.
    assign w_aw_fire = (r_state == S_RUN) && !r_awvalid && (w_remaining != '0) &&
                       !w_q_full && (w_avail >= c_cnt_w'(w_len));

`ifdef LAST_CHECK_EN
    logic w_last_exp;
    assign w_last_exp = (r_accepted[5:0] == 6'h3F) ||
                        (r_accepted == r_total_beats - c_cnt_w'(1));
    assign w_last_err = w_push && (last_i != w_last_exp);
`else
    logic w_unused_last;
    assign w_unused_last = last_i;
    assign w_last_err    = 1'b0;
`endif

    assign w_err_set = (w_b_hs && (m_bresp != 2'b00)) || w_last_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (w_start_beats == '0) ? S_DONE : S_RUN;
            S_RUN:   if (r_sent == r_total_beats) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_outstanding_b == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_total_beats   <= '0;
            r_tail_bytes    <= '0;
            r_accepted      <= '0;
            r_outstanding_b <= '0;
            r_bready        <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_bready <= 1'b1;
            if (w_start_ok) begin
                r_total_beats <= w_start_beats;
                r_tail_bytes  <= total_length[5:0];
                r_accepted    <= '0;
            end else if (w_push) begin
                r_accepted <= r_accepted + c_cnt_w'(1);
            end
            if (w_aw_hs && !w_b_hs)
                r_outstanding_b <= r_outstanding_b + c_cnt_w'(1);
            else if (!w_aw_hs && w_b_hs)
                r_outstanding_b <= r_outstanding_b - c_cnt_w'(1);
            if (w_start_ok)     r_error <= w_err_set;
            else if (w_err_set) r_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_addr <= '0;
            r_issued   <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_awvalid  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_cur_addr <= dest_addr;
                r_issued   <= '0;
            end else if (w_aw_hs) begin
                r_cur_addr <= r_cur_addr + ADDR_W'({r_awlen + 8'd1, 6'b0});
                r_issued   <= r_issued + c_cnt_w'(r_awlen) + c_cnt_w'(1);
            end
            if (w_aw_fire) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= r_cur_addr;
                r_awlen   <= {1'b0, w_len - 7'd1};
            end else if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_sent     <= '0;
            r_q_len[0] <= '0;
            r_q_len[1] <= '0;
            r_q_wr     <= 1'b0;
            r_q_rd     <= 1'b0;
            r_q_cnt    <= '0;
            r_beat_idx <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            r_fifo_cnt <= r_fifo_cnt + c_fcnt_w'(w_push) - c_fcnt_w'(w_pop);
            if (w_aw_hs) begin
                r_q_len[r_q_wr] <= r_awlen[6:0] + 7'd1;
                r_q_wr          <= ~r_q_wr;
            end
            r_q_cnt <= r_q_cnt + 2'(w_aw_hs) - 2'(w_pop && w_wlast);
            if (w_start_ok) begin
                r_sent <= '0;
            end else if (w_pop) begin
                r_sent   <= r_sent + c_cnt_w'(1);
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                if (w_wlast) begin
                    r_beat_idx <= '0;
                    r_q_rd     <= ~r_q_rd;
                end else begin
                    r_beat_idx <= r_beat_idx + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign ready_o   = (r_state == S_RUN) && !w_fifo_full && (r_accepted < r_total_beats);
    assign m_awaddr  = r_awaddr;
    assign m_awlen   = r_awlen;
    assign m_awvalid = r_awvalid;
    assign m_wvalid  = !w_fifo_empty && !w_q_empty;
    assign m_wdata   = m_wvalid ? r_mem[r_rd_ptr] : '0;
    assign m_wlast   = m_wvalid && w_wlast;
    // Partial strobe only on the transfer's final beat when the length is not 64B-aligned.
    assign m_wstrb   = !m_wvalid ? 64'd0 :
                       (w_final_beat && (r_tail_bytes != 6'd0)) ?
                       ((64'd1 << r_tail_bytes) - 64'd1) : {64{1'b1}};
    assign m_bready  = r_bready;
    assign done      = (r_state == S_DONE);
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dma_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_wr_burst_ctrl
// Brief  : Scoreboard bench with randomized AXI/stream handshakes for dma_wr_burst_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_dma_wr_burst_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  dest_addr = '0;
    logic [31:0]  total_length = '0;
    logic [511:0] data_i = '0;
    logic         valid_i = 1'b0;
    logic         last_i = 1'b0;
    logic         ready_o;
    logic [63:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic         m_awvalid;
    logic         m_awready = 1'b0;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wlast;
    logic         m_wvalid;
    logic         m_wready = 1'b0;
    logic [1:0]   m_bresp = 2'b00;
    logic         m_bvalid = 1'b0;
    logic         m_bready;
    logic         done;
    logic         error;

    always #5 clk = ~clk;

    dma_wr_burst_ctrl #(.ADDR_W(64), .FIFO_DEPTH(128), .MAX_BURST(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dest_addr(dest_addr),
        .total_length(total_length), .data_i(data_i), .valid_i(valid_i),
        .last_i(last_i), .ready_o(ready_o), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready), .done(done), .error(error)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [511:0] data; logic [63:0] strb; logic last; } w_t;

    aw_t          exp_aw[$];
    w_t           exp_w[$];
    logic [511:0] s_data[$];
    bit           s_last[$];
    int           s_idx = 0, s_n = 0;
    bit           s_force = 0, s_hs = 0, w_hold = 0;
    int           b_owed = 0, b_err_left = 0;
    int           checks = 0, errors = 0;
    int           done_cnt = 0, xfer_cnt = 0;
    bit           prev_done = 0, aw_wait = 0;
    logic [63:0]  aw_prev_addr = '0;
    logic [7:0]   aw_prev_len = '0;
    aw_t          aw_e;
    w_t           w_e;

`ifdef LAST_CHECK_EN
    localparam bit LAST_ERR_EXP = 1'b1;
`else
    localparam bit LAST_ERR_EXP = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic print_summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // Reference model: split the transfer into page-bounded bursts of at most
    // 64 beats and list every AW and W beat the slave should observe.
    task automatic load_xfer(input logic [63:0] addr, input int unsigned len_b, input int bad_idx);
        int unsigned beats;
        longint unsigned cur;
        int rem, idx, room, n;
        logic [511:0] d;
        aw_t a;
        w_t e;
        beats = (len_b + 63) / 64;
        s_data.delete();
        s_last.delete();
        for (int i = 0; i < int'(beats); i++) begin
            for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
            s_data.push_back(d);
            s_last.push_back(((i % 64) == 63) || (i == int'(beats) - 1) || (i == bad_idx));
        end
        cur = addr;
        rem = int'(beats);
        idx = 0;
        while (rem > 0) begin
            room = (4096 - int'(cur % 4096)) / 64;
            n = rem;
            if (n > 64) n = 64;
            if (n > room) n = room;
            a.addr = cur;
            a.len  = 8'(n - 1);
            exp_aw.push_back(a);
            for (int k = 0; k < n; k++) begin
                e.data = s_data[idx];
                e.last = (k == n - 1);
                e.strb = '1;
                if (idx == int'(beats) - 1 && (len_b % 64) != 0)
                    e.strb = (64'd1 << (len_b % 64)) - 64'd1;
                exp_w.push_back(e);
                idx++;
            end
            cur += 64 * n;
            rem -= n;
        end
        s_idx = 0;
        s_n   = int'(beats);
    endtask

    task automatic start_xfer(input logic [63:0] addr, input int unsigned len_b, input int bad_idx);
        @(posedge clk); #1;
        load_xfer(addr, len_b, bad_idx);
        dest_addr    = addr;
        total_length = len_b;
        start        = 1'b1;
        xfer_cnt++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("error_clear_on_start", {63'd0, error}, 64'd0);
    endtask

    task automatic wait_done(input string name, input int bound, input logic exp_err);
        bit got;
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done: no done pulse within %0d cycles", name, bound);
            print_summary();
            $finish;
        end
        chk({name, "_error"}, {63'd0, error}, {63'd0, exp_err});
    endtask

    task automatic run(input string name, input logic [63:0] addr, input int unsigned len_b,
                       input int bad_idx, input logic exp_err);
        start_xfer(addr, len_b, bad_idx);
        wait_done(name, (len_b == 0) ? 3 : 20000, exp_err);
    endtask

    // Stream source
    initial forever begin
        @(posedge clk); #1;
        if (s_hs) s_idx++;
        if (s_idx < s_n && (s_force || $urandom_range(0, 3) != 0)) begin
            valid_i = 1'b1;
            data_i  = s_data[s_idx];
            last_i  = s_last[s_idx];
        end else begin
            valid_i = 1'b0;
            last_i  = 1'b0;
        end
    end

    // AXI slave handshakes
    initial forever begin
        @(posedge clk); #1;
        m_awready = ($urandom_range(0, 2) != 0);
        m_wready  = !w_hold && ($urandom_range(0, 3) != 0);
        m_bvalid  = (b_owed > 0) && ($urandom_range(0, 1) != 0);
        m_bresp   = (m_bvalid && b_err_left > 0) ? 2'b10 : 2'b00;
    end

    // Monitor: every handshake is decided here, half a cycle before its edge.
    always @(negedge clk) begin
        s_hs = valid_i && ready_o;
        if (rst_n) begin
            if (m_awvalid) begin
                if (aw_wait) begin
                    chk("aw_addr_stable", m_awaddr, aw_prev_addr);
                    chk("aw_len_stable", {56'd0, m_awlen}, {56'd0, aw_prev_len});
                end
                if (m_awready) begin
                    aw_wait = 0;
                    if (exp_aw.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected: got addr 0x%0h, expected no AW", m_awaddr);
                    end else begin
                        aw_e = exp_aw.pop_front();
                        chk("aw_addr", m_awaddr, aw_e.addr);
                        chk("aw_len", {56'd0, m_awlen}, {56'd0, aw_e.len});
                    end
                end else begin
                    aw_wait = 1;
                    aw_prev_addr = m_awaddr;
                    aw_prev_len  = m_awlen;
                end
            end else begin
                aw_wait = 0;
            end
            if (m_wvalid && m_wready) begin
                if (exp_w.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_unexpected: got data %h, expected no W beat", m_wdata[63:0]);
                end else begin
                    w_e = exp_w.pop_front();
                    checks++;
                    if (m_wdata !== w_e.data) begin
                        errors++;
                        $display("FAIL w_data: got %h expected %h", m_wdata, w_e.data);
                    end
                    chk("w_strb", m_wstrb, w_e.strb);
                    chk("w_last", {63'd0, m_wlast}, {63'd0, w_e.last});
                end
                if (m_wlast) b_owed++;
            end
            if (m_bvalid && m_bready) begin
                b_owed--;
                if (m_bresp != 2'b00) b_err_left--;
            end
            if (done) begin
                chk("done_width", {63'd0, prev_done}, 64'd0);
                chk("done_aw_pending", 64'(exp_aw.size()), 64'd0);
                chk("done_w_pending", 64'(exp_w.size()), 64'd0);
                chk("done_b_pending", 64'(b_owed), 64'd0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    initial begin
        logic [63:0]  addr;
        int unsigned  len;
        bit           inj;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_o", {63'd0, ready_o}, 64'd0);
        chk("rst_awvalid", {63'd0, m_awvalid}, 64'd0);
        chk("rst_awaddr", m_awaddr, 64'd0);
        chk("rst_awlen", {56'd0, m_awlen}, 64'd0);
        chk("rst_wvalid", {63'd0, m_wvalid}, 64'd0);
        chk("rst_wlast", {63'd0, m_wlast}, 64'd0);
        chk("rst_wstrb", m_wstrb, 64'd0);
        chk("rst_wdata_nonzero", {63'd0, (m_wdata != '0)}, 64'd0);
        chk("rst_bready", {63'd0, m_bready}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("bready_after_reset", {63'd0, m_bready}, 64'd1);

        run("aligned_8k", 64'h1000, 8192, -1, 1'b0);
        run("page_cross_200", 64'hFC0, 200, -1, 1'b0);

        // W stalled: the FIFO fills to its depth and the stream is throttled.
        w_hold  = 1;
        s_force = 1;
        start_xfer(64'h2_0000, 16384, -1);
        repeat (500) @(posedge clk);
        #2;
        chk("full_ready_o", {63'd0, ready_o}, 64'd0);
        chk("full_accepted", 64'(s_idx), 64'd128);
        w_hold = 0;
        wait_done("backpressure", 20000, 1'b0);
        s_force = 0;

        run("zero_length", 64'h3000, 0, -1, 1'b0);

        // A start pulse while RUN must not disturb the transfer in flight.
        start_xfer(64'h5000, 8192, -1);
        repeat (20) @(posedge clk);
        #1;
        dest_addr    = 64'hDEAD_0000;
        total_length = 32'd64;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("start_in_run", 20000, 1'b0);

        b_err_left = 1;
        run("bresp_error", 64'h7000, 12288, -1, 1'b1);
        run("after_error", 64'h8040, 1000, -1, 1'b0);
        run("bad_last", 64'h9000, 4096, 10, LAST_ERR_EXP);

        for (int t = 0; t < 12; t++) begin
            addr = 64'($urandom_range(0, 4095)) * 64'd4096 + 64'($urandom_range(0, 63)) * 64'd64;
            if ($urandom_range(0, 3) == 0) addr = addr + 64'h1_0000_0000;
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9000);
            inj = (len != 0) && ($urandom_range(0, 3) == 0);
            b_err_left = inj ? 1 : 0;
            run("random", addr, len, -1, inj);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt), 64'(xfer_cnt));
        chk("end_aw_pending", 64'(exp_aw.size()), 64'd0);
        chk("end_w_pending", 64'(exp_w.size()), 64'd0);
        chk("end_stream_consumed", 64'(s_idx), 64'(s_n));
        print_summary();
        $finish;
    end

endmodule
`default_nettype wire
